ex_muldiv: RTL and testbench

Parametrised multi-cycle execute unit for the RV32M multiply/divide instructions. It sits beside the single-cycle ALU in the EX stage. It accepts one operation from ID/EX, iterates over several cycles, and holds the pipeline through `ex_stall_o` until the result is ready. It then presents the result together with the destination-register information for the EX/MEM latch.

---
 rtl/ex_muldiv.sv | 192 +++++++++++++++++++
 tb/tb_ex_muldiv.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - multi-cycle RV32M multiply/divide unit for the EX stage
module ex_muldiv #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] opr1_i,
  input  logic [XLEN-1:0] opr2_i,
  input  logic [4:0]      wd_i,
  input  logic            wreg_i,
  input  logic            flush_i,
  output logic            ex_stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      wd_o,
  output logic            wreg_o
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_BITS - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_op;
  logic [4:0]          r_wd;
  logic                r_wreg;
  logic                r_sign_q;   // product / quotient must be negated
  logic                r_sign_r;   // remainder must be negated (dividend sign)
  logic [XLEN-1:0]     r_mcand;    // multiplicand magnitude, or divisor magnitude
  logic [2*XLEN-1:0]   r_acc;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [CW-1:0]       r_cnt;

  // Operand decode for the accepting cycle
  logic                w_accept;
  logic                w_div0;
  logic                w_s1_signed;
  logic                w_s2_signed;
  logic                w_neg1;
  logic                w_neg2;
  logic [XLEN-1:0]     w_mag1;
  logic [XLEN-1:0]     w_mag2;

  assign w_accept    = start_i & ~flush_i;
  assign w_div0      = op_i[2] & (opr2_i == '0);
  assign w_s1_signed = ~((op_i == 3'd3) | (op_i[2] & op_i[0]));
  assign w_s2_signed = ~((~op_i[2] & op_i[1]) | (op_i[2] & op_i[0]));
  assign w_neg1      = w_s1_signed & opr1_i[XLEN-1];
  assign w_neg2      = w_s2_signed & opr2_i[XLEN-1];
  assign w_mag1      = w_neg1 ? -opr1_i : opr1_i;
  assign w_mag2      = w_neg2 ? -opr2_i : opr2_i;

  // Shift-add step: add multiplicand * low digit to the upper half, shift right by MUL_BITS
  logic [MUL_BITS-1:0]      w_digit;
  logic [XLEN+MUL_BITS-1:0] w_pp;
  logic [XLEN+MUL_BITS-1:0] w_sum;
  logic [2*XLEN-1:0]        w_mul_next;
  logic [2*XLEN-1:0]        w_prod;

  assign w_digit    = r_acc[MUL_BITS-1:0];
  assign w_pp       = {{MUL_BITS{1'b0}}, r_mcand} * {{XLEN{1'b0}}, w_digit};
  assign w_sum      = {{MUL_BITS{1'b0}}, r_acc[2*XLEN-1:XLEN]} + w_pp;
  assign w_mul_next = {w_sum, r_acc[XLEN-1:MUL_BITS]};
  assign w_prod     = r_sign_q ? -w_mul_next : w_mul_next;

  // Restoring step: remainder < divisor always holds, so the borrow bit is a valid compare
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_n;
  logic [XLEN-1:0] w_quo_n;
  logic [XLEN-1:0] w_quo_s;
  logic [XLEN-1:0] w_rem_s;

  assign w_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_mcand};
  assign w_ge    = ~w_diff[XLEN];
  assign w_rem_n = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_n = {r_acc[XLEN-2:0], w_ge};
  assign w_quo_s = r_sign_q ? -w_quo_n : w_quo_n;
  assign w_rem_s = r_sign_r ? -w_rem_n : w_rem_n;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; flush wins over completion while iterating
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = op_i[2] ? (w_div0 ? S_DONE : S_DIV) : S_MUL;
      S_MUL: begin
        if (flush_i)                  w_next = S_IDLE;
        else if (r_cnt == MUL_LAST)   w_next = S_DONE;
      end
      S_DIV: begin
        if (flush_i)                  w_next = S_IDLE;
        else if (r_cnt == DIV_LAST)   w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Pipeline hold: busy, or accepting this cycle; released in DONE
  always_comb begin
    ex_stall_o = 1'b0;
    case (r_state)
      S_IDLE:       ex_stall_o = w_accept;
      S_MUL, S_DIV: ex_stall_o = 1'b1;
      default:      ex_stall_o = 1'b0;
    endcase
  end

  // Operand capture, iteration datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_wd     <= '0;
      r_wreg   <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      done_o   <= 1'b0;
      wreg_o   <= 1'b0;
      wd_o     <= '0;
      result_o <= '0;
    end else begin
      done_o <= 1'b0;
      wreg_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op     <= op_i;
            r_wd     <= wd_i;
            r_wreg   <= wreg_i;
            r_cnt    <= '0;
            r_sign_q <= w_neg1 ^ w_neg2;
            r_sign_r <= w_neg1;
            if (op_i[2]) begin
              r_mcand <= w_mag2;
              r_acc   <= {{XLEN{1'b0}}, w_mag1};
            end else begin
              r_mcand <= w_mag1;
              r_acc   <= {{XLEN{1'b0}}, w_mag2};
            end
            if (w_div0) begin
              done_o   <= 1'b1;
              wreg_o   <= wreg_i;
              wd_o     <= wd_i;
              result_o <= op_i[1] ? opr1_i : '1;
            end
          end
        end
        S_MUL: begin
          if (!flush_i) begin
            r_acc <= w_mul_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == MUL_LAST) begin
              done_o   <= 1'b1;
              wreg_o   <= r_wreg;
              wd_o     <= r_wd;
              result_o <= (r_op == 3'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
            end
          end
        end
        S_DIV: begin
          if (!flush_i) begin
            r_acc <= {w_rem_n, w_quo_n};
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == DIV_LAST) begin
              done_o   <= 1'b1;
              wreg_o   <= r_wreg;
              wd_o     <= r_wd;
              result_o <= r_op[1] ? w_rem_s : w_quo_s;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - self-checking bench for ex_muldiv at 32/2, 16/1 and 16/4
module tb_ex_muldiv;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  wd = '0;
  logic        wreg = 1'b0;
  logic        flush = 1'b0;

  logic [2:0]  stall_w;
  logic [2:0]  done_w;
  logic [2:0]  wreg_w;
  logic [31:0] res0;
  logic [15:0] res1;
  logic [15:0] res2;
  logic [4:0]  wdo0, wdo1, wdo2;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_exp [3];

  ex_muldiv #(.XLEN(32), .MUL_BITS(2)) u_x32 (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .opr1_i(a), .opr2_i(b),
    .wd_i(wd), .wreg_i(wreg), .flush_i(flush), .ex_stall_o(stall_w[0]),
    .done_o(done_w[0]), .result_o(res0), .wd_o(wdo0), .wreg_o(wreg_w[0]));

  ex_muldiv #(.XLEN(16), .MUL_BITS(1)) u_x16m1 (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .opr1_i(a[15:0]), .opr2_i(b[15:0]),
    .wd_i(wd), .wreg_i(wreg), .flush_i(flush), .ex_stall_o(stall_w[1]),
    .done_o(done_w[1]), .result_o(res1), .wd_o(wdo1), .wreg_o(wreg_w[1]));

  ex_muldiv #(.XLEN(16), .MUL_BITS(4)) u_x16m4 (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .opr1_i(a[15:0]), .opr2_i(b[15:0]),
    .wd_i(wd), .wreg_i(wreg), .flush_i(flush), .ex_stall_o(stall_w[2]),
    .done_o(done_w[2]), .result_o(res2), .wd_o(wdo2), .wreg_o(wreg_w[2]));

  function automatic int wid(int i);
    return (i == 0) ? 32 : 16;
  endfunction

  function automatic int mbits(int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  function automatic logic [31:0] get_res(int i);
    return (i == 0) ? res0 : ((i == 1) ? {16'h0, res1} : {16'h0, res2});
  endfunction

  function automatic logic [31:0] get_wd(int i);
    return {27'h0, (i == 0) ? wdo0 : ((i == 1) ? wdo1 : wdo2)};
  endfunction

  // Reference: plain integer arithmetic on w-bit operands, RISC-V special cases included
  function automatic logic [31:0] ref_model(int w, logic [2:0] o, logic [31:0] x, logic [31:0] y);
    longint mask, ua, ub, sa, sb, r;
    logic signed [127:0] px, py, p, ph;
    mask = (longint'(1) << w) - 1;
    ua = longint'(x) & mask;
    ub = longint'(y) & mask;
    sa = ((ua >> (w - 1)) != 0) ? ua - (mask + 1) : ua;
    sb = ((ub >> (w - 1)) != 0) ? ub - (mask + 1) : ub;
    r = 0;
    px = (o == 3'd3) ? ua : sa;
    py = (o == 3'd2 || o == 3'd3) ? ub : sb;
    p  = px * py;
    ph = p >>> w;
    case (o)
      3'd0: r = longint'(p[63:0]);
      3'd1, 3'd2, 3'd3: r = longint'(ph[63:0]);
      3'd4: r = (ub == 0) ? mask : sa / sb;
      3'd5: r = (ub == 0) ? mask : ua / ub;
      3'd6: r = (ub == 0) ? ua : sa % sb;
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return 32'(r & mask);
  endfunction

  task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=0x%08h expected=0x%08h", tag, i, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_done"}, i, {31'h0, done_w[i]}, 32'h0);
      check({tag, "_wreg"}, i, {31'h0, wreg_w[i]}, 32'h0);
      check({tag, "_stall"}, i, {31'h0, stall_w[i]}, 32'h0);
      check({tag, "_result"}, i, get_res(i), last_exp[i]);
    end
  endtask

  // Issue one op to all three instances and check result, latency, stall and tags
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] d, input logic we,
                        input logic use_c, input logic [31:0] c32);
    logic [31:0] exp [3];
    int lat [3];
    int seen [3];
    bit all_seen;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] ym;
      ym = (i == 0) ? y : {16'h0, y[15:0]};
      exp[i]  = ref_model(wid(i), o, x, y);
      lat[i]  = (o[2] && ym == 0) ? 1 : (o[2] ? wid(i) + 1 : wid(i) / mbits(i) + 1);
      seen[i] = -1;
    end
    @(negedge clk);
    op = o; a = x; b = y; wd = d; wreg = we; start = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) check("stall_accept", i, {31'h0, stall_w[i]}, 32'h1);
    all_seen = 1'b0;
    for (int c = 1; c <= 80 && !all_seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      all_seen = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (seen[i] < 0) begin
          if (done_w[i]) begin
            seen[i] = c;
            check("result", i, get_res(i), exp[i]);
            check("wd", i, get_wd(i), {27'h0, d});
            check("wreg", i, {31'h0, wreg_w[i]}, {31'h0, we});
            check("stall_done", i, {31'h0, stall_w[i]}, 32'h0);
            if (i == 0 && use_c) check("result_const", i, get_res(i), c32);
            last_exp[i] = exp[i];
          end else begin
            check("stall_busy", i, {31'h0, stall_w[i]}, 32'h1);
            all_seen = 1'b0;
          end
        end
      end
    end
    for (int i = 0; i < 3; i++) check("latency", i, 32'(seen[i]), 32'(lat[i]));
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("done_pulse_end", i, {31'h0, done_w[i]}, 32'h0);
      check("wreg_gated", i, {31'h0, wreg_w[i]}, 32'h0);
    end
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (done_w[i]) pulses++;
    end
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'h0000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_8000;
      4: return 32'(($urandom_range(0, 15)));
      default: return $urandom;
    endcase
  endfunction

  logic [2:0]  t_op [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd4, 3'd7, 3'd4, 3'd6};
  logic [31:0] t_a  [12] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'd5, 32'd5,
                             32'h80000000, 32'h80000000};
  logic [31:0] t_b  [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2,
                             32'd3, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] t_e  [12] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,
                             32'hFFFFFFFD, 32'hFFFFFFFF, 32'h2AAAAAAA, 32'hFFFFFFFF, 32'h00000005,
                             32'h80000000, 32'h00000000};

  initial begin
    int pulses;
    for (int i = 0; i < 3; i++) last_exp[i] = 32'h0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    for (int i = 0; i < 3; i++) check("reset_wd", i, get_wd(i), 32'h0);
    rst = 1'b0;

    // Directed operations with known 32-bit answers
    for (int k = 0; k < 12; k++)
      run_op(t_op[k], t_a[k], t_b[k], 5'(k + 1), k[0], 1'b1, t_e[k]);

    // Random operations against the model
    for (int k = 0; k < 40; k++)
      run_op(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0, 32'h0);

    // Flush in cycle 10 of a divide
    @(negedge clk);
    op = 3'd4; a = 32'h1234_5678; b = 32'h0001_0003; wd = 5'd17; wreg = 1'b1; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_idle_outputs("flush_div");
    count_pulses(40, pulses);
    check("flush_div_no_done", 0, 32'(pulses), 32'h0);

    // Start and flush together in IDLE: discarded
    @(negedge clk);
    op = 3'd0; a = 32'd3; b = 32'd5; start = 1'b1; flush = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) check("flush_idle_stall", i, {31'h0, stall_w[i]}, 32'h0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    count_pulses(30, pulses);
    check("flush_idle_no_done", 0, 32'(pulses), 32'h0);

    // Unit still works after flushes, then reset in cycle 5 of a multiply
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd9, 1'b1, 1'b1, 32'hFFFFFFEB);
    @(negedge clk);
    op = 3'd1; a = 32'h0BAD_F00D; b = 32'h1234_5679; wd = 5'd22; wreg = 1'b1; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 5) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) last_exp[i] = 32'h0;
    check_idle_outputs("reset_mid_mul");
    for (int i = 0; i < 3; i++) check("reset_mid_mul_wd", i, get_wd(i), 32'h0);
    count_pulses(30, pulses);
    check("reset_mid_mul_no_done", 0, 32'(pulses), 32'h0);

    run_op(3'd7, 32'd100, 32'd7, 5'd3, 1'b1, 1'b1, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
